bsg_wormhole_packet_injector: RTL and testbench
===============================================

# bsg_wormhole_packet_injector

Serializes one fully-formed packet (destination coordinate, length, up to `max_payload_flits_p` payload flits) into a wormhole flit stream. The stream drives the local (P) input port of the chip's wormhole router. The block sits directly upstream of the router's local link and builds the header flit in the router's format: cord in the LSBs, then len.

## Interface
- `flit_width_p`, default `flit_width_gp`: flit width in bits.
- `cord_width_p`, default `cord_width_gp`: destination coordinate width.
- `len_width_p`, default `len_width_gp`: header length field width.
- `max_payload_flits_p`, default 4: payload flit capacity; must be ≤ 2^`len_width_p`−1.
- `clk_i`  in  1  clock.
- `reset_i`  in  1  reset; synchronous, active-high.
- `packet_v_i`  in  1  packet valid.
- `packet_ready_and_o`  out  1  packet accepted when `packet_v_i` and this signal are both high.
- `packet_cord_i`  in  `cord_width_p`  destination coordinate.
- `packet_len_i`  in  `len_width_p`  number of payload flits following the header (0 allowed).
- `packet_data_i`  in  `max_payload_flits_p*flit_width_p`  payload; flit k is bits [k*flit_width_p +: flit_width_p].
- `flit_v_o`  out  1  flit valid toward router.
- `flit_data_o`  out  `flit_width_p`  flit.
- `flit_ready_and_i`  in  1  router accepts the flit.
- `error_o`  out  1  sticky oversize error (see Configuration).

## Operation
- FSM with three states: IDLE, HDR, BODY.
- IDLE:
  - `packet_ready_and_o`=1 and `flit_v_o`=0.
  - On accept, latch cord, len and data into internal registers and go to HDR.
- HDR:
  - `flit_v_o`=1.
  - `flit_data_o` = {zeros, len_r, cord_r}: cord in [cord_width_p-1:0], len in the next `len_width_p` bits, all upper bits 0.
  - On handshake: if len_r==0, go to IDLE; otherwise clear cnt_r and go to BODY.
- BODY:
  - `flit_v_o`=1 and `flit_data_o` = data_r flit[cnt_r].
  - On handshake: if cnt_r==len_r−1, go to IDLE; otherwise increment cnt_r.
- `packet_ready_and_o` is high only in IDLE. There is no accept-during-last-flit bypass.
- Once `flit_v_o` rises, the flit stays asserted and `flit_data_o` stays stable until the handshake.
- cnt_r width is `$clog2(max_payload_flits_p)` (minimum 1). It never wraps inside legal packets.
- Latched registers are not updated outside the IDLE accept.
- Reset mid-packet returns to IDLE and drops the partial packet. Recovery of the partial worm in the router is the system's responsibility.

## Timing
- Reset values:
  - state=IDLE, so `flit_v_o`=0, `packet_ready_and_o`=1, `error_o`=0.
  - `flit_data_o` is don't-care while `flit_v_o`=0.
- Accept in cycle N puts the header on `flit_v_o` in cycle N+1. With continuous ready, payload flit k is presented in cycle N+2+k.
- Packet of L payload flits with zero backpressure: the next accept is possible in cycle N+L+2. Steady throughput is (L+1)/(L+2).
- Outputs are functions of registered state only. There is no combinational path from `flit_ready_and_i` to `flit_v_o` or `flit_data_o`, or from `packet_v_i` to `packet_ready_and_o`.

## Configuration
- `BSG_WH_INJECTOR_LEN_CHECK_EN` defined:
  - An accepted packet with `packet_len_i` > `max_payload_flits_p` is consumed but not injected; the FSM stays in IDLE.
  - `error_o` is set the next cycle and held until reset.
- Not defined:
  - No check is made and `error_o` is tied 0.
  - Such input is illegal. The header carries len verbatim, and body flit index saturates at `max_payload_flits_p`−1, so the last word is repeated.

## Structure
- `bsg_chip_pkg` additions:
  - packed typedef `bsg_wh_injector_hdr_s` {pad, len, cord}, sized from `flit_width_gp`/`len_width_gp`/`cord_width_gp`;
  - constant `max_payload_flits_gp`.
- One sub-module, `bsg_mux`, selects payload flit[cnt_r]. The FSM, counter and latch stay in this module.

## Test plan
All scenarios use flit 32, cord 8, len 4, max 4.
- Reset then idle: `flit_v_o`=0, `packet_ready_and_o`=1, `error_o`=0 every cycle.
- Accept cord=0x12, len=0 with ready held 1 -> single flit 0x0000_0012 in cycle N+1; ready_and high again in N+2.
- Accept cord=0x03, len=3, data words {0xA,0xB,0xC} with ready held 1 -> 0x0000_0303, 0xA, 0xB, 0xC in N+1..N+4, then IDLE.
- Same packet with `flit_ready_and_i` low for 2 cycles on the second body flit -> 0xB held stable with v=1 through the stall; total 6 flit-cycles.
- Assert `reset_i` in BODY after the first payload flit -> `flit_v_o`=0 the next cycle; a fresh packet is then injected correctly.
- With `BSG_WH_INJECTOR_LEN_CHECK_EN`, accept len=5 -> no flit_v, `error_o`=1 from N+1 until reset; a following len=1 packet is still injected.

Source files
------------

// File: rtl/bsg_wormhole_packet_injector_pkg.sv
// Shared widths, FSM states and the router header layout for the packet injector.
// Header flit layout: cord in the LSBs, len above it, zero padding on top.
package bsg_wormhole_packet_injector_pkg;

  localparam int flit_width_gp        = 32;
  localparam int cord_width_gp        = 8;
  localparam int len_width_gp         = 4;
  localparam int max_payload_flits_gp = 4;

  typedef enum logic [1:0] {
    e_idle = 2'd0,
    e_hdr  = 2'd1,
    e_body = 2'd2
  } inj_state_e;

  typedef struct packed {
    logic [flit_width_gp-len_width_gp-cord_width_gp-1:0] pad;
    logic [len_width_gp-1:0]                             len;
    logic [cord_width_gp-1:0]                            cord;
  } bsg_wh_injector_hdr_s;

  // An index into n elements needs at least one bit, even when n is 1.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_wormhole_packet_injector_if.sv
// Packet-side and flit-side handshake bundle of the injector.
// The slave modport is the injector; the master modport is whoever feeds it and sinks its flits.
interface bsg_wormhole_packet_injector_if
  import bsg_wormhole_packet_injector_pkg::*;
#(
  parameter int flit_width_p        = flit_width_gp,
  parameter int cord_width_p        = cord_width_gp,
  parameter int len_width_p         = len_width_gp,
  parameter int max_payload_flits_p = max_payload_flits_gp
);

  logic                                        packet_v_i;
  logic                                        packet_ready_and_o;
  logic [cord_width_p-1:0]                     packet_cord_i;
  logic [len_width_p-1:0]                      packet_len_i;
  logic [max_payload_flits_p*flit_width_p-1:0] packet_data_i;
  logic                                        flit_v_o;
  logic [flit_width_p-1:0]                     flit_data_o;
  logic                                        flit_ready_and_i;
  logic                                        error_o;

  modport slave (
    input  packet_v_i, packet_cord_i, packet_len_i, packet_data_i, flit_ready_and_i,
    output packet_ready_and_o, flit_v_o, flit_data_o, error_o
  );

  modport master (
    output packet_v_i, packet_cord_i, packet_len_i, packet_data_i, flit_ready_and_i,
    input  packet_ready_and_o, flit_v_o, flit_data_o, error_o
  );

endinterface

// File: rtl/bsg_wormhole_packet_injector_mux.sv
// bsg_mux: picks element sel_i out of a packed array of els_p words; purely combinational.
module bsg_mux
  import bsg_wormhole_packet_injector_pkg::*;
#(
  parameter int width_p = 1,
  parameter int els_p   = 2,
  localparam int lg_els_lp = idx_width(els_p)
) (
  input  logic [els_p*width_p-1:0] data_i,
  input  logic [lg_els_lp-1:0]     sel_i,
  output logic [width_p-1:0]       data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < els_p; i++) begin
      if (sel_i == lg_els_lp'(i)) data_o = data_i[i*width_p +: width_p];
    end
  end

endmodule

// File: rtl/bsg_wormhole_packet_injector.sv
// Serializes a latched packet into header + payload flits for the router P port; header one cycle after accept.
// Accepts only when idle; flits hold until flit_ready_and_i. BSG_WH_INJECTOR_LEN_CHECK_EN drops oversize packets and sets error_o.
module bsg_wormhole_packet_injector
  import bsg_wormhole_packet_injector_pkg::*;
#(
  parameter int flit_width_p        = flit_width_gp,
  parameter int cord_width_p        = cord_width_gp,
  parameter int len_width_p         = len_width_gp,
  parameter int max_payload_flits_p = max_payload_flits_gp
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  bsg_wormhole_packet_injector_if.slave       io
);

  localparam int data_width_lp = max_payload_flits_p * flit_width_p;
  localparam int cnt_width_lp  = idx_width(max_payload_flits_p);
  localparam logic [cnt_width_lp-1:0] cnt_last_lp = cnt_width_lp'(max_payload_flits_p - 1);

  inj_state_e                state_q, state_d;
  logic [cord_width_p-1:0]   cord_q, cord_d;
  logic [len_width_p-1:0]    len_q, len_d;
  logic [data_width_lp-1:0]  data_q, data_d;
  logic [cnt_width_lp-1:0]   cnt_q, cnt_d;
  logic [len_width_p-1:0]    rem_q, rem_d;

  logic                      packet_ready;
  logic                      flit_v;
  logic [flit_width_p-1:0]   flit_data;
  logic [flit_width_p-1:0]   body_flit;
  bsg_wh_injector_hdr_s      hdr;

`ifdef BSG_WH_INJECTOR_LEN_CHECK_EN
  localparam logic [len_width_p-1:0] max_len_lp = len_width_p'(max_payload_flits_p);
  logic error_q, error_d;
`endif

  bsg_mux #(
    .width_p (flit_width_p),
    .els_p   (max_payload_flits_p)
  ) payload_mux (
    .data_i (data_q),
    .sel_i  (cnt_q),
    .data_o (body_flit)
  );

  always_comb begin
    hdr      = '0;
    hdr.len  = len_q;
    hdr.cord = cord_q;
  end

  // cnt_q indexes the payload and saturates; rem_q counts flits left so oversize lengths still terminate.
  always_comb begin
    state_d      = state_q;
    cord_d       = cord_q;
    len_d        = len_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
`ifdef BSG_WH_INJECTOR_LEN_CHECK_EN
    error_d      = error_q;
`endif
    packet_ready = 1'b0;
    flit_v       = 1'b0;
    flit_data    = '0;

    case (state_q)
      e_idle: begin
        packet_ready = 1'b1;
        if (io.packet_v_i) begin
          cord_d = io.packet_cord_i;
          len_d  = io.packet_len_i;
          data_d = io.packet_data_i;
`ifdef BSG_WH_INJECTOR_LEN_CHECK_EN
          if (io.packet_len_i > max_len_lp) error_d = 1'b1;
          else                              state_d = e_hdr;
`else
          state_d = e_hdr;
`endif
        end
      end
      e_hdr: begin
        flit_v    = 1'b1;
        flit_data = hdr;
        if (io.flit_ready_and_i) begin
          if (len_q == '0) begin
            state_d = e_idle;
          end else begin
            cnt_d   = '0;
            rem_d   = len_q - 1'b1;
            state_d = e_body;
          end
        end
      end
      e_body: begin
        flit_v    = 1'b1;
        flit_data = body_flit;
        if (io.flit_ready_and_i) begin
          if (rem_q == '0) begin
            state_d = e_idle;
          end else begin
            rem_d = rem_q - 1'b1;
            if (cnt_q != cnt_last_lp) cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = e_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_idle;
      cnt_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
    end
  end

  always_ff @(posedge clk_i) begin
    cord_q <= cord_d;
    len_q  <= len_d;
    data_q <= data_d;
  end

`ifdef BSG_WH_INJECTOR_LEN_CHECK_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) error_q <= 1'b0;
    else         error_q <= error_d;
  end
  assign io.error_o = error_q;
`else
  assign io.error_o = 1'b0;
`endif

  assign io.packet_ready_and_o = packet_ready;
  assign io.flit_v_o           = flit_v;
  assign io.flit_data_o        = flit_data;

endmodule

// File: tb/tb_bsg_wormhole_packet_injector.sv
// Bench for bsg_wormhole_packet_injector: queue-based flit model checked every cycle, plus directed literal scenarios.
module tb_bsg_wormhole_packet_injector;
  import bsg_wormhole_packet_injector_pkg::*;

  localparam int FW   = 32;
  localparam int CW   = 8;
  localparam int LW   = 4;
  localparam int MAXF = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bsg_wormhole_packet_injector_if #(
    .flit_width_p(FW), .cord_width_p(CW), .len_width_p(LW), .max_payload_flits_p(MAXF)
  ) io ();

  bsg_wormhole_packet_injector #(
    .flit_width_p(FW), .cord_width_p(CW), .len_width_p(LW), .max_payload_flits_p(MAXF)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .io      (io)
  );

  typedef struct {
    int          c;
    logic [31:0] d;
  } hs_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          n_acc    = 0;
  int          acc_cyc  = 0;
  int          vcycles  = 0;
  int          rdy_mode = 0;
  bit          model_on = 0;
  bit          m_err    = 0;
  logic [31:0] exp_q[$];
  hs_t         hs_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: an accepted packet becomes a list of flits the router must see, in order.
  task automatic model_accept();
    logic [LW-1:0] len;
    len = io.packet_len_i;
`ifdef BSG_WH_INJECTOR_LEN_CHECK_EN
    if (int'(len) > MAXF) begin
      m_err = 1'b1;
      return;
    end
`endif
    exp_q.push_back((32'(len) << CW) | 32'(io.packet_cord_i));
    for (int k = 0; k < int'(len); k++) begin
      int s;
      s = (k < MAXF) ? k : MAXF - 1;
      exp_q.push_back(io.packet_data_i[s*FW +: FW]);
    end
  endtask

  always @(negedge clk) begin
    bit idle;
    if (model_on) begin
      idle = (exp_q.size() == 0);
      check("packet_ready", 32'(io.packet_ready_and_o), 32'(idle));
      check("flit_v", 32'(io.flit_v_o), 32'(!idle));
      if (!idle) check("flit_data", io.flit_data_o, exp_q[0]);
      check("error", 32'(io.error_o), 32'(m_err));
    end
    if (io.flit_v_o === 1'b1) vcycles++;
    if (io.flit_v_o === 1'b1 && io.flit_ready_and_i === 1'b1) hs_log.push_back('{cyc, io.flit_data_o});
    if (reset) begin
      exp_q.delete();
      m_err    = 1'b0;
      model_on = 1'b1;
    end else if (model_on) begin
      idle = (exp_q.size() == 0);
      if (!idle && io.flit_ready_and_i) void'(exp_q.pop_front());
      if (idle && io.packet_v_i) begin
        acc_cyc = cyc;
        n_acc++;
        model_accept();
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       io.flit_ready_and_i = 1'b1;
      1:       io.flit_ready_and_i = ($urandom_range(0, 3) != 0);
      default: io.flit_ready_and_i = !(cyc == acc_cyc + 3 || cyc == acc_cyc + 4);
    endcase
  end

  task automatic send_pkt(input logic [CW-1:0] cord, input logic [LW-1:0] len, input logic [MAXF*FW-1:0] data);
    int n0;
    bit got;
    n0  = n_acc;
    got = 1'b0;
    @(posedge clk); #1;
    io.packet_v_i    = 1'b1;
    io.packet_cord_i = cord;
    io.packet_len_i  = len;
    io.packet_data_i = data;
    for (int i = 0; i < 300 && !got; i++) begin
      @(posedge clk);
      if (n_acc != n0) got = 1'b1;
    end
    #1;
    io.packet_v_i    = 1'b0;
    io.packet_cord_i = CW'($urandom);
    io.packet_len_i  = LW'($urandom);
    io.packet_data_i = {$urandom, $urandom, $urandom, $urandom};
    check("accept_timeout", 32'(got), 32'd1);
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && io.packet_ready_and_o === 1'b1) done = 1'b1;
    end
    check("drain_timeout", 32'(done), 32'd1);
  endtask

  task automatic check_log(input string name, input int base, input int n,
                           input int offs[8], input logic [31:0] dat[8]);
    check({name, "_count"}, 32'(hs_log.size()), 32'(n));
    for (int i = 0; i < n && i < hs_log.size(); i++) begin
      check({name, "_cycle"}, 32'(hs_log[i].c), 32'(base + offs[i]));
      check({name, "_data"}, hs_log[i].d, dat[i]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int v0;
    io.packet_v_i    = 1'b0;
    io.packet_cord_i = '0;
    io.packet_len_i  = '0;
    io.packet_data_i = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    repeat (3) begin
      @(negedge clk);
      check("reset_flit_v", 32'(io.flit_v_o), 32'd0);
      check("reset_ready", 32'(io.packet_ready_and_o), 32'd1);
      check("reset_error", 32'(io.error_o), 32'd0);
    end

    // Zero-length packet: header only, ready again two cycles after accept.
    hs_log.delete();
    send_pkt(8'h12, 4'd0, '0);
    n = acc_cyc;
    @(negedge clk);
    @(negedge clk);
    check("len0_ready_again", 32'(io.packet_ready_and_o), 32'd1);
    check("len0_v_low", 32'(io.flit_v_o), 32'd0);
    check_log("len0", n, 1, '{1, 0, 0, 0, 0, 0, 0, 0},
              '{32'h0000_0012, 0, 0, 0, 0, 0, 0, 0});

    hs_log.delete();
    send_pkt(8'h03, 4'd3, {32'h0, 32'hC, 32'hB, 32'hA});
    n = acc_cyc;
    wait_drain();
    check_log("len3", n, 4, '{1, 2, 3, 4, 0, 0, 0, 0},
              '{32'h0000_0303, 32'hA, 32'hB, 32'hC, 0, 0, 0, 0});

    // Router stalls the second body flit for two cycles.
    rdy_mode = 2;
    hs_log.delete();
    v0 = vcycles;
    send_pkt(8'h03, 4'd3, {32'h0, 32'hC, 32'hB, 32'hA});
    n = acc_cyc;
    wait_drain();
    check_log("stall", n, 4, '{1, 2, 5, 6, 0, 0, 0, 0},
              '{32'h0000_0303, 32'hA, 32'hB, 32'hC, 0, 0, 0, 0});
    check("stall_vcycles", 32'(vcycles - v0), 32'd6);
    rdy_mode = 0;
    repeat (6) @(posedge clk);

    // Reset after the first payload flit, then a clean packet.
    hs_log.delete();
    send_pkt(8'h03, 4'd3, {32'h0, 32'hC, 32'hB, 32'hA});
    for (int i = 0; i < 50 && hs_log.size() < 2; i++) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midreset_flit_v", 32'(io.flit_v_o), 32'd0);
    check("midreset_ready", 32'(io.packet_ready_and_o), 32'd1);
    hs_log.delete();
    send_pkt(8'h55, 4'd2, {32'h0, 32'h0, 32'h22, 32'h11});
    n = acc_cyc;
    wait_drain();
    check_log("after_reset", n, 3, '{1, 2, 3, 0, 0, 0, 0, 0},
              '{32'h0000_0255, 32'h11, 32'h22, 0, 0, 0, 0, 0});

`ifdef BSG_WH_INJECTOR_LEN_CHECK_EN
    hs_log.delete();
    send_pkt(8'h07, 4'd5, {32'h4, 32'h3, 32'h2, 32'h1});
    @(negedge clk);
    check("oversize_error", 32'(io.error_o), 32'd1);
    check("oversize_no_flit", 32'(io.flit_v_o), 32'd0);
    check("oversize_ready", 32'(io.packet_ready_and_o), 32'd1);
    send_pkt(8'h09, 4'd1, {32'h0, 32'h0, 32'h0, 32'h77});
    n = acc_cyc;
    wait_drain();
    check_log("after_oversize", n, 2, '{1, 2, 0, 0, 0, 0, 0, 0},
              '{32'h0000_0109, 32'h77, 0, 0, 0, 0, 0, 0});
    check("error_sticky", 32'(io.error_o), 32'd1);
`else
    hs_log.delete();
    send_pkt(8'h01, 4'd6, {32'hD, 32'hC, 32'hB, 32'hA});
    n = acc_cyc;
    wait_drain();
    check_log("oversize_sat", n, 7, '{1, 2, 3, 4, 5, 6, 7, 0},
              '{32'h0000_0601, 32'hA, 32'hB, 32'hC, 32'hD, 32'hD, 32'hD, 0});
    check("no_check_error", 32'(io.error_o), 32'd0);
`endif

    rdy_mode = 1;
    for (int p = 0; p < 150; p++) begin
      logic [LW-1:0] len;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      if ($urandom_range(0, 7) == 0) len = LW'($urandom_range(MAXF + 1, 15));
      else                           len = LW'($urandom_range(0, MAXF));
      send_pkt(CW'($urandom), len, {$urandom, $urandom, $urandom, $urandom});
    end
    rdy_mode = 0;
    wait_drain();

    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("final_reset_error", 32'(io.error_o), 32'd0);
    check("final_reset_v", 32'(io.flit_v_o), 32'd0);
    check("final_reset_ready", 32'(io.packet_ready_and_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
